// File: rtl/conv_window_feeder_pkg.sv
// Shared constants, state encoding and address helpers for the conv window feeder.
// Window geometry is derived from the line/kernel/stride constants below.
package conv_window_feeder_pkg;

  localparam int KERNEL_SIZE  = 32;
  localparam int DATA_LENGTH  = 512;
  localparam int DATA_WIDTH   = 8;
  localparam int WEIGHT_WIDTH = 8;
  localparam int BIAS_WIDTH   = 8;
  localparam int STRIDES      = 8;
  localparam int ADDR_WIDTH   = 9;
  localparam int RELU_WIDTH   = 8;
  localparam int BEAT_WIDTH   = $clog2(KERNEL_SIZE);
  localparam int IDX_WIDTH    = 6;

  function automatic int calc_win_count(input int length, input int kernel, input int stride);
    return (length - kernel) / stride + 1;
  endfunction

  localparam int WIN_COUNT      = calc_win_count(DATA_LENGTH, KERNEL_SIZE, STRIDES);
  localparam bit STRIDE_IS_POW2 = ((STRIDES & (STRIDES - 1)) == 0);
  localparam int STRIDE_SHIFT   = $clog2(STRIDES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_BURST  = 3'd1,
    ST_D_BURST  = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_DONE     = 3'd4
  } fsm_state_e;

  // First sample address of a window; a plain shift when the stride is a power of two.
  function automatic logic [ADDR_WIDTH-1:0] win_base(input logic [IDX_WIDTH-1:0] win);
    if (STRIDE_IS_POW2) return ADDR_WIDTH'(win) << STRIDE_SHIFT;
    else                return ADDR_WIDTH'(32'(win) * STRIDES);
  endfunction

endpackage

// File: rtl/conv_window_feeder_burst_addr_gen.sv
// Beat counter and base+offset address generator shared by the weight and data bursts.
// beat_valid trails the issued address by one cycle to match the 1-cycle memory read.
module conv_window_feeder_burst_addr_gen
  import conv_window_feeder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [BEAT_WIDTH-1:0] beat,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  beat_valid
);

  assign last = (beat == BEAT_WIDTH'(KERNEL_SIZE - 1));
  assign addr = base + ADDR_WIDTH'(beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat       <= '0;
      beat_valid <= 1'b0;
    end else begin
      beat_valid <= run;
      if (run && !last) beat <= beat + 1'b1;
      else              beat <= '0;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Sequencer feeding one kernel and a 1-D feature line to the 32-tap multiply-adder,
// one window per stride position, and collecting each window's 8-bit result.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [BEAT_WIDTH-1:0]   w_addr,
  input  logic [WEIGHT_WIDTH-1:0] w_rdata,
  input  logic [BIAS_WIDTH-1:0]   bias_in,
  output logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    weight_en,
  output logic                    Multiply_en,
  output logic [WEIGHT_WIDTH-1:0] weight_out,
  output logic [BIAS_WIDTH-1:0]   bias_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    beat_valid,
  input  logic                    conv_end,
  input  logic [RELU_WIDTH-1:0]   result_in,
  output logic                    res_valid,
  output logic [RELU_WIDTH-1:0]   res_data,
  output logic [IDX_WIDTH-1:0]    res_index,
  output logic [2:0]              fsm_state
);

  // Handshake: weight_en / Multiply_en open a burst, then beat_valid is high for exactly
  // KERNEL_SIZE consecutive cycles with the beat on weight_out / data_out; there is no
  // back-pressure. conv_end is only honoured in WAIT_END, including its first cycle.

  fsm_state_e               state, state_nxt;
  logic [IDX_WIDTH-1:0]     win_cnt;
  logic                     run;
  logic                     last;
  logic                     w_beat, d_beat;
  logic [BEAT_WIDTH-1:0]    beat;
  logic [ADDR_WIDTH-1:0]    base, addr;
  logic                     last_win;

  assign last_win = (win_cnt == IDX_WIDTH'(WIN_COUNT - 1));
  assign base     = (state == ST_D_BURST) ? win_base(win_cnt) : '0;

  conv_window_feeder_burst_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .base       (base),
    .beat       (beat),
    .last       (last),
    .addr       (addr),
    .beat_valid (beat_valid)
  );

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_W_BURST;
      ST_W_BURST: begin
        run = 1'b1;
        if (last) state_nxt = ST_D_BURST;
      end
      ST_D_BURST: begin
        run = 1'b1;
        if (last) state_nxt = ST_WAIT_END;
      end
      ST_WAIT_END: if (conv_end) state_nxt = last_win ? ST_DONE : ST_D_BURST;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      win_cnt   <= '0;
      bias_out  <= '0;
      w_beat    <= 1'b0;
      d_beat    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
    end else begin
      state     <= state_nxt;
      w_beat    <= (state == ST_W_BURST);
      d_beat    <= (state == ST_D_BURST);
      res_valid <= 1'b0;
      if (state == ST_IDLE && start) begin
        bias_out <= bias_in;
        win_cnt  <= '0;
      end
      if (state == ST_WAIT_END && conv_end) begin
        res_valid <= 1'b1;
        res_data  <= result_in;
        res_index <= win_cnt;
        if (!last_win) win_cnt <= win_cnt + 1'b1;
      end
    end
  end

  // Beat data is gated so idle and reset leave the data outputs at zero.
  assign weight_out  = w_beat ? w_rdata : '0;
  assign data_out    = d_beat ? d_rdata : '0;
  assign w_addr      = (state == ST_W_BURST) ? addr[BEAT_WIDTH-1:0] : '0;
  assign d_addr      = (state == ST_D_BURST) ? addr : '0;
  assign weight_en   = (state == ST_W_BURST) && (beat == '0);
  assign Multiply_en = (state == ST_D_BURST) && (beat == '0);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign fsm_state   = state;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomized bench for conv_window_feeder: memory models, a multiply-adder responder and
// a scoreboard whose expected beat stream is built from the window geometry.
module tb_conv_window_feeder;
  import conv_window_feeder_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic                    busy, done;
  logic [BEAT_WIDTH-1:0]   w_addr;
  logic [WEIGHT_WIDTH-1:0] w_rdata;
  logic [BIAS_WIDTH-1:0]   bias_in;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_rdata;
  logic                    weight_en, Multiply_en;
  logic [WEIGHT_WIDTH-1:0] weight_out;
  logic [BIAS_WIDTH-1:0]   bias_out;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    beat_valid;
  logic                    conv_end;
  logic [RELU_WIDTH-1:0]   result_in;
  logic                    res_valid;
  logic [RELU_WIDTH-1:0]   res_data;
  logic [IDX_WIDTH-1:0]    res_index;
  logic [2:0]              fsm_state;

  // clock / reset
  always #5 clk = ~clk;

  conv_window_feeder dut (
    .clk (clk), .rst (rst), .start (start), .busy (busy), .done (done),
    .w_addr (w_addr), .w_rdata (w_rdata), .bias_in (bias_in),
    .d_addr (d_addr), .d_rdata (d_rdata),
    .weight_en (weight_en), .Multiply_en (Multiply_en),
    .weight_out (weight_out), .bias_out (bias_out), .data_out (data_out),
    .beat_valid (beat_valid), .conv_end (conv_end), .result_in (result_in),
    .res_valid (res_valid), .res_data (res_data), .res_index (res_index),
    .fsm_state (fsm_state)
  );

  // synchronous-read memories
  logic [7:0] w_mem [KERNEL_SIZE];
  logic [7:0] d_mem [DATA_LENGTH];
  always @(posedge clk) begin
    w_rdata <= w_mem[w_addr];
    d_rdata <= d_mem[d_addr];
  end

  logic [57:0] outs_vec;
  assign outs_vec = {busy, done, w_addr, d_addr, weight_en, Multiply_en, weight_out,
                     bias_out, data_out, beat_valid, res_valid, res_data, res_index};

  logic resp_conv, stray_conv;
  assign conv_end = resp_conv | stray_conv;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard + multiply-adder responder
  logic [8:0]  exp_q[$];
  logic [13:0] res_q[$];
  logic        arm, clear_sb, hit, delay_mode;
  int          beat_cnt, pend, pend_win, done_cnt;
  logic [7:0]  pend_val;

  task automatic fire_result();
    resp_conv = 1'b1;
    result_in = pend_val;
    res_q.push_back({6'(pend_win), pend_val});
    pend = -1;
  endtask

  initial begin
    logic [8:0]  e;
    logic [13:0] r;
    int d;
    beat_cnt = 0; pend = -1; done_cnt = 0; hit = 1'b0;
    resp_conv = 1'b0; result_in = '0; pend_win = 0; pend_val = '0;
    forever begin
      @(negedge clk);
      if (clear_sb) begin
        exp_q.delete(); res_q.delete();
        beat_cnt = 0; pend = -1; hit = 1'b0; resp_conv = 1'b0;
      end else begin
        if (arm) begin
          exp_q.delete(); res_q.delete(); beat_cnt = 0; pend = -1;
          for (int k = 0; k < KERNEL_SIZE; k++) exp_q.push_back({1'b1, w_mem[k]});
          for (int w = 0; w < WIN_COUNT; w++)
            for (int k = 0; k < KERNEL_SIZE; k++)
              exp_q.push_back({1'b0, d_mem[w*STRIDES + k]});
        end
        resp_conv = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) fire_result();
        end
        if (beat_valid) begin
          if (exp_q.size() == 0) check("beat_extra", 1, 0);
          else begin
            e = exp_q.pop_front();
            if (e[8]) check("weight_beat", weight_out, e[7:0]);
            else      check("data_beat", data_out, e[7:0]);
          end
          beat_cnt++;
          if (beat_cnt == KERNEL_SIZE*6 + 18) hit = 1'b1;
          if (beat_cnt > KERNEL_SIZE && (beat_cnt % KERNEL_SIZE) == 0) begin
            pend_win = beat_cnt / KERNEL_SIZE - 2;
            pend_val = (pend_win == 3) ? 8'h5A : 8'($urandom_range(0, 255));
            d = delay_mode ? int'($urandom_range(0, 4)) : 2;
            if (d == 0) fire_result();
            else pend = d;
          end
        end
        if (res_valid) begin
          if (res_q.size() == 0) check("res_unexpected", 1, 0);
          else begin
            r = res_q.pop_front();
            check("res_idx_data", {res_index, res_data}, r);
            check("next_mul_en", Multiply_en, r[13:8] != 6'(WIN_COUNT - 1));
            check("done_at_last", done, r[13:8] == 6'(WIN_COUNT - 1));
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  // driver tasks
  task automatic start_line(input logic [7:0] b);
    @(posedge clk); #2;
    bias_in = b; start = 1'b1; arm = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; arm = 1'b0; bias_in = ~b;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check({tag, "_done"}, seen, 1);
    repeat (3) @(negedge clk);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_res_left"}, res_q.size(), 0);
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < KERNEL_SIZE; k++) w_mem[k] = 8'($urandom_range(0, 255));
    for (int a = 0; a < DATA_LENGTH; a++) d_mem[a] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; bias_in = '0; arm = 1'b0; clear_sb = 1'b0;
    stray_conv = 1'b0; delay_mode = 1'b0;
    for (int k = 0; k < KERNEL_SIZE; k++) w_mem[k] = 8'(k + 1);
    for (int a = 0; a < DATA_LENGTH; a++) d_mem[a] = 8'(a);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outs", outs_vec, 0);
    end

    // line 1: directed weight-burst timing, fixed conv_end latency
    start_line(8'hC3);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      check("weight_en_cyc", weight_en, i == 1);
      check("mul_en_cyc", Multiply_en, i == 33);
      check("beat_valid_cyc", beat_valid, i >= 2);
      if (i == 1) begin
        check("w_addr_first", w_addr, 0);
        check("busy_first", busy, 1);
        check("bias_latched", bias_out, 8'hC3);
      end
    end
    wait_done("line1");
    check("bias_held", bias_out, 8'hC3);

    // line 2: random data and latency, stray conv_end and start while busy
    randomize_mem();
    delay_mode = 1'b1;
    start_line(8'h11);
    repeat (9) @(posedge clk);
    #2 stray_conv = 1'b1;
    @(posedge clk); #2 stray_conv = 1'b0;
    repeat (39) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    check("restart_ignored", fsm_state, ST_D_BURST);
    check("no_weight_en", weight_en, 0);
    wait_done("line2");
    check("bias_line2", bias_out, 8'h11);

    // line 3: reset at beat 17 of window 5
    randomize_mem();
    start_line(8'h42);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (hit) begin seen = 1'b1; break; end
    end
    check("reach_w5_b17", seen, 1);
    rst = 1'b1;
    #1;
    check("rst_async_outs", outs_vec, 0);
    check("rst_async_state", fsm_state, ST_IDLE);
    clear_sb = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); #1 clear_sb = 1'b0;
    check("post_rst_idle", outs_vec, 0);

    // line 4: full restart from window 0 with a weight burst
    randomize_mem();
    start_line(8'h7E);
    @(negedge clk);
    check("restart_weight_en", weight_en, 1);
    check("restart_w_addr", w_addr, 0);
    check("restart_bias", bias_out, 8'h7E);
    wait_done("line4");
    check("done_count", done_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Initiator-side sequencer for the 32-tap multiply-adder.
- Reads one kernel's weights and bias, plus a 1-D feature line, from synchronous-read memories.
- Sends them serially over the weight_en / Multiply_en + 32-beat protocol, one window per stride position.
- Waits for conv_end from the multiply-adder before starting the next window; collects the 8-bit outputs with their window index.

Parameters:
- KERNEL_SIZE, 32: taps per window; also beats per burst.
- DATA_LENGTH, 512: samples in the feature line.
- DATA_WIDTH, 8: feature sample width.
- WEIGHT_WIDTH, 8: weight width.
- BIAS_WIDTH, 8: bias width.
- STRIDES, 8: window step in samples.
- ADDR_WIDTH, 9: data memory address width.
- WIN_COUNT, (DATA_LENGTH-KERNEL_SIZE)/STRIDES+1 = 61: windows per line.

Ports:
- clk, in, 1: clock; all logic rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse; begins a line; ignored unless IDLE.
- busy, out, 1: high from the cycle after an accepted start until DONE exits.
- done, out, 1: one-cycle pulse after the last window's result.
- w_addr, out, 5: weight memory address (0..31).
- w_rdata, in, WEIGHT_WIDTH: weight memory data; 1-cycle read latency.
- bias_in, in, BIAS_WIDTH: kernel bias; sampled at start.
- d_addr, out, ADDR_WIDTH: data memory address.
- d_rdata, in, DATA_WIDTH: data memory data; 1-cycle read latency.
- weight_en, out, 1: one-cycle pulse opening the weight burst.
- Multiply_en, out, 1: one-cycle pulse opening each data burst.
- weight_out, out, WEIGHT_WIDTH: weight beat (= w_rdata).
- bias_out, out, BIAS_WIDTH: registered bias, held stable for the whole line.
- data_out, out, DATA_WIDTH: data beat (= d_rdata).
- beat_valid, out, 1: high on each of the 32 beats of a burst.
- conv_end, in, 1: multiply-adder result strobe.
- result_in, in, 8: multiply-adder output (ReLU-truncated).
- res_valid, out, 1: one-cycle pulse with each captured result.
- res_data, out, 8: captured result.
- res_index, out, 6: window index of res_data.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; bias_out 0.
- States: IDLE, W_BURST, D_BURST, WAIT_END, DONE.
- IDLE:
  - start=1 -> latch bias_in into bias_out; win_cnt=0; go to W_BURST.
  - start=0 -> stay.
- W_BURST (32 cycles):
  - Cycle 0: weight_en=1, w_addr=0.
  - Cycle k: w_addr=k.
  - beat_valid is a registered copy of "address issued", so beats land on cycles 1..32, with weight_out carrying w[0..31].
  - After the cycle-31 address -> D_BURST.
- D_BURST (32 cycles):
  - Cycle 0: Multiply_en=1.
  - Cycle k: d_addr = win_cnt*STRIDES + k.
  - Beats 1..32 carry x[base..base+31].
  - First D_BURST entry: its cycle 0 coincides with weight beat 32. beat_valid stays continuous; it never has a gap or a double assert.
  - After address 31 -> WAIT_END.
- WAIT_END:
  - On conv_end=1 (any cycle from the last beat onward): res_data <= result_in, res_index <= win_cnt, res_valid pulse.
  - win_cnt == WIN_COUNT-1 -> DONE; otherwise win_cnt++ and -> D_BURST (weights are not resent).
  - No timeout; the FSM waits indefinitely.
- DONE: done=1 for one cycle -> IDLE.
- Address arithmetic:
  - win_cnt*STRIDES is built as shift-add for power-of-two STRIDES; the generic path is a multiply.
  - The max address, (WIN_COUNT-1)*STRIDES + KERNEL_SIZE - 1 = 511, fits in ADDR_WIDTH with no wrap.
- Boundary conditions:
  - start while busy: ignored; no restart.
  - conv_end outside WAIT_END: ignored.
  - conv_end in the same cycle the FSM enters WAIT_END: accepted.
  - rst mid-burst: immediate return to IDLE with outputs cleared. The multiply-adder must also be reset, because its partial burst is discarded.
- res_index width of 6 bits covers 61 windows.

Decomposition:
- Shared package holds:
  - FSM state encoding
  - KERNEL_SIZE / STRIDES / WIN_COUNT derivation function
  - ReLU output width constant (8)
- Natural sub-module: burst_addr_gen. It contains the 5-bit beat counter, base + offset address generation, and the 1-cycle-delayed beat_valid. It is instanced once and shared by the weight and data phases.

Test Plan:
- Reset then idle: rst 1->0, no start -> all outputs 0 for 100 cycles; w_addr = d_addr = 0.
- Weight burst: w_mem[k]=k+1; pulse start -> weight_en at cycle 1 after start. beat_valid high cycles 2..33, weight_out = 1..32 in order; Multiply_en pulse at the cycle of weight beat 32.
- Window addressing: d_mem[a]=a[7:0]; model conv_end 2 cycles after the last beat -> window 0 beats 0..31, window 1 beats 8..39, window 60 beats 480..511; res_index runs 0..60; one done pulse after index 60.
- Result capture: result_in=8'h5A with conv_end in window 3 -> res_valid once, res_data=8'h5A, res_index=3; the next Multiply_en follows 1 cycle later.
- Protocol robustness: start pulsed during D_BURST and conv_end pulsed during W_BURST -> no state change, no extra res_valid, addresses unchanged.
- Reset mid-operation: assert rst at beat 17 of window 5 -> all outputs 0 within the same cycle (async). A later start restarts at window 0 with a full weight burst.
